hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port ID_Rs, input, 5 bits: source register of the instruction in ID.
REQ-004 SHALL have port ID_Rt, input, 5 bits: second source register of the instruction in ID.
REQ-005 SHALL have port ID_uses_Rt, input, 1 bit: ID instruction reads Rt.
REQ-006 SHALL have port EX_MemtoReg, input, 1 bit: low means the EX instruction is a load.
REQ-007 SHALL have port EX_WR_out, input, 5 bits: destination register of the EX instruction.
REQ-008 SHALL have port EX_jump_taken, input, 1 bit: branch or jump resolved taken in EX.
REQ-009 SHALL have port D_req, input, 1 bit: M-stage data-cache access valid.
REQ-010 SHALL have port D_ready, input, 1 bit: data cache hit, or refill complete.
REQ-011 SHALL have port PCWrite, output, 1 bit: PC update enable.
REQ-012 SHALL have port IF_IDWrite, output, 1 bit: IF_ID register write enable.
REQ-013 SHALL have port IF_Flush, output, 1 bit: clear IF_ID.
REQ-014 SHALL have port ID_EXWrite, output, 1 bit: ID_EX write enable.
REQ-015 SHALL have port ID_Flush, output, 1 bit: bubble into ID_EX; it overrides ID_EXWrite in that register.
REQ-016 SHALL have port EX_MWrite, output, 1 bit: EX_M register write enable.
REQ-017 SHALL have port M_WBFlush, output, 1 bit: bubble into M_WB.
REQ-018 SHALL have port stall_cnt, output, 16 bits: stall-cycle counter.
REQ-019 SHALL have port miss_timeout, output, 1 bit: sticky watchdog flag.

Function
REQ-020 SHALL implement a two-state FSM with states RUN and MISS; outputs are combinational from state and inputs.
REQ-021 SHALL detect load-use as: EX_MemtoReg==0, EX_WR_out!=0, and (EX_WR_out==ID_Rs or (ID_uses_Rt and EX_WR_out==ID_Rt)).
REQ-022 SHALL treat a miss as D_req==1 and D_ready==0.
REQ-023 SHALL, in RUN with no event: drive PCWrite, IF_IDWrite, ID_EXWrite and EX_MWrite to 1, and IF_Flush, ID_Flush and M_WBFlush to 0.
REQ-024 SHALL, in RUN on load-use only: PCWrite=0, IF_IDWrite=0, ID_Flush=1, others as REQ-023; exactly one bubble per detection.
REQ-025 SHALL, in RUN on EX_jump_taken: IF_Flush=1, ID_Flush=1, PCWrite=1, IF_IDWrite=1; jump overrides a simultaneous load-use.
REQ-026 SHALL, on a miss (in RUN or MISS): drive PCWrite, IF_IDWrite, ID_EXWrite, EX_MWrite, IF_Flush and ID_Flush to 0, and M_WBFlush to 1.
REQ-027 SHALL give a miss priority over jump and load-use; jump and load-use are ignored while the miss persists and are re-evaluated after it clears.
REQ-028 SHALL move RUN->MISS on a miss, and MISS->RUN in the cycle after D_ready==1 is sampled.
REQ-029 SHALL, in the D_ready==1 cycle, revert outputs to the RUN rules (REQ-023..025) for that same cycle.
REQ-030 SHALL use stall_cnt to count every cycle where PCWrite==0; 16-bit unsigned, saturating at 0xFFFF with no wrap.
REQ-031 SHALL use an 8-bit miss-duration counter that clears on MISS entry and increments each MISS cycle.
REQ-032 SHALL set miss_timeout when the miss-duration counter reaches 255; miss_timeout stays set until rst; the counter saturates at 255.
REQ-033 SHALL NOT use miss_timeout to alter pipeline control.

Reset
REQ-034 SHALL, with rst high at a clock edge: state=RUN, stall_cnt=0, miss-duration counter=0, miss_timeout=0.
REQ-035 SHALL, while rst is high: PCWrite=0, IF_IDWrite=0, ID_EXWrite=0, EX_MWrite=0, IF_Flush=1, ID_Flush=1, M_WBFlush=1.
REQ-036 SHALL give rst priority over all events, including mid-miss; the first cycle after rst is RUN with normal outputs.

Verification
REQ-037 SHALL cover: EX_MemtoReg=0, EX_WR_out=8, ID_Rs=8 for one cycle -> PCWrite=0, IF_IDWrite=0, ID_Flush=1 for 1 cycle; stall_cnt=1.
REQ-038 SHALL cover: load-use with EX_WR_out=0, or ID_Rt match with ID_uses_Rt=0 -> no stall.
REQ-039 SHALL cover: load-use and EX_jump_taken in the same cycle -> IF_Flush=1, ID_Flush=1, PCWrite=1; stall_cnt unchanged.
REQ-040 SHALL cover: D_req=1, D_ready=0 for 5 cycles, then D_ready=1 -> all write enables 0 and M_WBFlush=1 for 5 cycles; RUN outputs in the 6th cycle; stall_cnt=5.
REQ-041 SHALL cover: miss held for 300 cycles -> miss_timeout rises after 255 MISS cycles and stays 1 after the miss clears, until rst.
REQ-042 SHALL cover: rst asserted in cycle 3 of a miss -> next cycle state RUN, stall_cnt=0, REQ-035 outputs during rst.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-jump flushes and data-cache
// miss freezes, with a saturating stall counter and a sticky miss watchdog.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_uses_Rt,
  input  logic        EX_MemtoReg,
  input  logic [4:0]  EX_WR_out,
  input  logic        EX_jump_taken,
  input  logic        D_req,
  input  logic        D_ready,
  output logic        PCWrite,
  output logic        IF_IDWrite,
  output logic        IF_Flush,
  output logic        ID_EXWrite,
  output logic        ID_Flush,
  output logic        EX_MWrite,
  output logic        M_WBFlush,
  output logic [15:0] stall_cnt,
  output logic        miss_timeout
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_miss;
  logic        w_load_use;
  logic [7:0]  r_miss_cnt;
  logic [7:0]  w_miss_cnt_next;
  logic [15:0] r_stall_cnt;
  logic        r_miss_timeout;

  // EX_MemtoReg low marks a load; register 0 never creates a dependency.
  assign w_load_use = !EX_MemtoReg && (EX_WR_out != 5'd0) &&
                      ((EX_WR_out == ID_Rs) || (ID_uses_Rt && (EX_WR_out == ID_Rt)));
  assign w_miss     = D_req && !D_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Priority: reset, then miss, then jump, then load-use.
  always_comb begin
    w_state_next = ST_RUN;
    PCWrite      = 1'b1;
    IF_IDWrite   = 1'b1;
    IF_Flush     = 1'b0;
    ID_EXWrite   = 1'b1;
    ID_Flush     = 1'b0;
    EX_MWrite    = 1'b1;
    M_WBFlush    = 1'b0;
    if (rst) begin
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXWrite = 1'b0;
      EX_MWrite  = 1'b0;
      IF_Flush   = 1'b1;
      ID_Flush   = 1'b1;
      M_WBFlush  = 1'b1;
    end else if (w_miss) begin
      w_state_next = ST_MISS;
      PCWrite      = 1'b0;
      IF_IDWrite   = 1'b0;
      ID_EXWrite   = 1'b0;
      EX_MWrite    = 1'b0;
      M_WBFlush    = 1'b1;
    end else if (EX_jump_taken) begin
      IF_Flush = 1'b1;
      ID_Flush = 1'b1;
    end else if (w_load_use) begin
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_Flush   = 1'b1;
    end
  end

  // Miss duration counts cycles spent in MISS; cleared on the RUN->MISS transition.
  always_comb begin
    w_miss_cnt_next = r_miss_cnt;
    if (r_state == ST_RUN && w_state_next == ST_MISS) begin
      w_miss_cnt_next = 8'd0;
    end else if (r_state == ST_MISS && r_miss_cnt != 8'hFF) begin
      w_miss_cnt_next = r_miss_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss_cnt     <= 8'd0;
      r_stall_cnt    <= 16'd0;
      r_miss_timeout <= 1'b0;
    end else begin
      r_miss_cnt <= w_miss_cnt_next;
      if (!PCWrite && r_stall_cnt != 16'hFFFF) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_miss_cnt_next == 8'hFF) begin
        r_miss_timeout <= 1'b1;
      end
    end
  end

  assign stall_cnt    = r_stall_cnt;
  assign miss_timeout = r_miss_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of single-cycle vectors in RUN plus
// hand-written miss, watchdog and mid-miss reset sequences.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_Rs, ID_Rt, EX_WR_out;
  logic        ID_uses_Rt, EX_MemtoReg, EX_jump_taken, D_req, D_ready;
  logic        PCWrite, IF_IDWrite, IF_Flush, ID_EXWrite, ID_Flush, EX_MWrite, M_WBFlush;
  logic [15:0] stall_cnt;
  logic        miss_timeout;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_Rt(ID_uses_Rt),
    .EX_MemtoReg(EX_MemtoReg), .EX_WR_out(EX_WR_out), .EX_jump_taken(EX_jump_taken),
    .D_req(D_req), .D_ready(D_ready),
    .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .IF_Flush(IF_Flush),
    .ID_EXWrite(ID_EXWrite), .ID_Flush(ID_Flush), .EX_MWrite(EX_MWrite),
    .M_WBFlush(M_WBFlush), .stall_cnt(stall_cnt), .miss_timeout(miss_timeout)
  );

  always #5 clk = ~clk;

  // Output bundle order: {PCWrite, IF_IDWrite, IF_Flush, ID_EXWrite, ID_Flush, EX_MWrite, M_WBFlush}
  localparam logic [6:0] NORM  = 7'b1101010;
  localparam logic [6:0] STALL = 7'b0001110;
  localparam logic [6:0] JUMP  = 7'b1111110;
  localparam logic [6:0] MISSO = 7'b0000001;
  localparam logic [6:0] RSTO  = 7'b0010101;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       uses_rt, memtoreg;
    logic [4:0] wr;
    logic       jump, dreq, dready;
    logic [6:0] exp;
  } vec_t;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [15:0] exp_stall = 16'd0;
  vec_t        tbl[12];

  function automatic vec_t mk(input string n, input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses, input logic mem, input logic [4:0] wr,
                              input logic jmp, input logic dreq, input logic drdy,
                              input logic [6:0] exp);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.uses_rt = uses; v.memtoreg = mem;
    v.wr = wr; v.jump = jmp; v.dreq = dreq; v.dready = drdy; v.exp = exp;
    return v;
  endfunction

  task automatic check_bit(input string n, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", n, act, exp);
    end
  endtask

  // Apply one cycle: drive after the edge, check outputs at negedge, check stall_cnt after the edge.
  task automatic run_vec(input vec_t v);
    logic [6:0] act;
    ID_Rs = v.rs; ID_Rt = v.rt; ID_uses_Rt = v.uses_rt; EX_MemtoReg = v.memtoreg;
    EX_WR_out = v.wr; EX_jump_taken = v.jump; D_req = v.dreq; D_ready = v.dready;
    @(negedge clk);
    act = {PCWrite, IF_IDWrite, IF_Flush, ID_EXWrite, ID_Flush, EX_MWrite, M_WBFlush};
    n_vec++;
    if (act !== v.exp) begin
      n_fail++;
      $display("FAIL %s outputs: got %b, expected %b", v.name, act, v.exp);
    end
    if (rst) exp_stall = 16'd0;
    else if (!v.exp[6] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    @(posedge clk);
    #1;
    n_vec++;
    if (stall_cnt !== exp_stall) begin
      n_fail++;
      $display("FAIL %s stall_cnt: got %0d, expected %0d", v.name, stall_cnt, exp_stall);
    end
    $display("vec %-16s out=%b stall_cnt=%0d timeout=%b", v.name, act, stall_cnt, miss_timeout);
  endtask

  initial begin
    tbl[0]  = mk("idle",          5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, NORM);
    tbl[1]  = mk("lu_rs",         5'd8, 5'd2, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, STALL);
    tbl[2]  = mk("after_bubble",  5'd3, 5'd4, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, NORM);
    tbl[3]  = mk("lu_r0",         5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
    tbl[4]  = mk("rt_unused",     5'd1, 5'd9, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, NORM);
    tbl[5]  = mk("lu_rt",         5'd1, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, STALL);
    tbl[6]  = mk("not_load",      5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, NORM);
    tbl[7]  = mk("lu_and_jump",   5'd8, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, JUMP);
    tbl[8]  = mk("jump",          5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, JUMP);
    tbl[9]  = mk("dcache_hit",    5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, NORM);
    tbl[10] = mk("hit_lu",        5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1, STALL);
    tbl[11] = mk("no_req",        5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, NORM);

    // Reset: outputs forced, counters cleared
    rst = 1'b1;
    run_vec(mk("reset0", 5'd8, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, RSTO));
    run_vec(mk("reset1", 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, RSTO));
    check_bit("timeout_reset", miss_timeout, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Five miss cycles with jump and load-use ignored, then ready with a jump pending
    for (int i = 0; i < 5; i++)
      run_vec(mk("miss5", 5'd8, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, MISSO));
    run_vec(mk("miss_ready_jmp", 5'd8, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, JUMP));
    run_vec(mk("post_miss_lu",  5'd8, 5'd2, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, STALL));
    check_bit("stall_cnt_is_9", (stall_cnt == 16'd9), 1'b1);

    // Long miss: watchdog rises after 255 cycles in MISS and stays set
    for (int i = 0; i < 300; i++) begin
      run_vec(mk("long_miss", 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, MISSO));
      if (i == 100) check_bit("timeout_at_100", miss_timeout, 1'b0);
      if (i == 254) check_bit("timeout_at_254", miss_timeout, 1'b0);
      if (i == 255) check_bit("timeout_at_255", miss_timeout, 1'b1);
    end
    run_vec(mk("miss_clear", 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, NORM));
    run_vec(mk("run_after",  5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, NORM));
    check_bit("timeout_sticky", miss_timeout, 1'b1);
    rst = 1'b1;
    run_vec(mk("rst_timeout", 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, RSTO));
    check_bit("timeout_cleared", miss_timeout, 1'b0);
    rst = 1'b0;

    // Reset in the third cycle of a miss
    run_vec(mk("miss_c1", 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, MISSO));
    run_vec(mk("miss_c2", 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, MISSO));
    rst = 1'b1;
    run_vec(mk("miss_c3_rst", 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, RSTO));
    rst = 1'b0;
    check_bit("stall_zero_after_rst", (stall_cnt == 16'd0), 1'b1);
    run_vec(mk("run_after_rst", 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, NORM));
    run_vec(mk("lu_after_rst",  5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, STALL));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
